// File: rtl/ccd_line_capture.sv
// ccd_line_capture: samples one CCD line per SH pulse, drops dummy pixels,
// averages optical-black pixels and stores black-corrected active pixels.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   SH, RS            driver timing: SH rise starts a line, RS fall marks a pixel
//   adc_data          ADC sample, captured SAMPLE_DLY clocks after each RS fall
//   bl_en             1 = subtract black level, 0 = store raw samples
//   cpu_irq           CPU acknowledge, rising edge releases a completed line
//   rd_addr, rd_data  CPU read port, one clock latency
//   rd_irq            line ready, held until acknowledged
//   ob_level          black average of the last completed line
//   overrun           sticky: a line started while the previous one was unread
//   short_line        sticky: a line was cut short by an early SH
module ccd_line_capture #(
    parameter int ADC_W      = 12,
    parameter int DUMMY_PIX  = 16,
    parameter int OB_LOG2    = 3,
    parameter int ACTIVE_PIX = 2048,
    parameter int AW         = 11,
    parameter int SAMPLE_DLY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SH,
    input  logic             RS,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             bl_en,
    input  logic             cpu_irq,
    input  logic [AW-1:0]    rd_addr,
    output logic [ADC_W-1:0] rd_data,
    output logic             rd_irq,
    output logic [ADC_W-1:0] ob_level,
    output logic             overrun,
    output logic             short_line
);
    localparam int OB_N  = 2 ** OB_LOG2;
    localparam int CW    = $clog2((DUMMY_PIX > OB_N ? DUMMY_PIX : OB_N) + 1);
    localparam int ACC_W = ADC_W + OB_LOG2;
    localparam logic [CW-1:0] LAST_DUMMY = CW'(DUMMY_PIX - 1);
    localparam logic [CW-1:0] LAST_OB    = CW'(OB_N - 1);
    localparam logic [AW-1:0] LAST_PIX   = AW'(ACTIVE_PIX - 1);

    typedef enum logic [2:0] {IDLE, DUMMY, BLACK, ACTIVE, DONE} state_t;

    state_t                  state_q;
    logic                    sh_q, rs_q, cpu_q;
    logic [SAMPLE_DLY-1:0]   dly_q;
    logic [CW-1:0]           cnt_q;
    logic [AW-1:0]           pix_q;
    logic [ACC_W-1:0]        acc_q;
    logic [ADC_W-1:0]        ob_avg_q;
    logic [ADC_W-1:0]        mem [2**AW];

    logic             sh_rise, rs_fall, ack, strobe, wr_en;
    logic [ACC_W-1:0] acc_d;
    logic [ADC_W:0]   diff;
    logic [ADC_W-1:0] pix_val;

    assign sh_rise = SH & ~sh_q;
    assign rs_fall = ~RS & rs_q;
    assign ack     = cpu_irq & ~cpu_q;
    assign strobe  = dly_q[SAMPLE_DLY-1];
    assign acc_d   = acc_q + ACC_W'(adc_data);
    // Extra MSB of the difference is the borrow, used to clamp at zero.
    assign diff    = {1'b0, adc_data} - {1'b0, ob_avg_q};
    assign pix_val = bl_en ? (diff[ADC_W] ? '0 : diff[ADC_W-1:0]) : adc_data;
    // An abort in the same cycle as a strobe takes priority, so no write.
    assign wr_en   = (state_q == ACTIVE) & strobe & ~sh_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sh_q       <= 1'b0;
            rs_q       <= 1'b0;
            cpu_q      <= 1'b0;
            dly_q      <= '0;
            cnt_q      <= '0;
            pix_q      <= '0;
            acc_q      <= '0;
            ob_avg_q   <= '0;
            rd_data    <= '0;
            rd_irq     <= 1'b0;
            ob_level   <= '0;
            overrun    <= 1'b0;
            short_line <= 1'b0;
        end else begin
            sh_q    <= SH;
            rs_q    <= RS;
            cpu_q   <= cpu_irq;
            dly_q   <= SAMPLE_DLY'({dly_q, rs_fall});
            rd_data <= mem[rd_addr];
            // Start or restart a line; DONE handles SH separately below.
            if (sh_rise && state_q != DONE) begin
                state_q <= DUMMY;
                cnt_q   <= '0;
                pix_q   <= '0;
                acc_q   <= '0;
                if (state_q != IDLE) short_line <= 1'b1;
            end else begin
                case (state_q)
                    DUMMY: if (strobe) begin
                        cnt_q <= cnt_q == LAST_DUMMY ? '0 : cnt_q + 1'b1;
                        if (cnt_q == LAST_DUMMY) state_q <= BLACK;
                    end
                    BLACK: if (strobe) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q == LAST_OB ? '0 : cnt_q + 1'b1;
                        if (cnt_q == LAST_OB) begin
                            ob_avg_q <= acc_d[ACC_W-1:OB_LOG2];
                            state_q  <= ACTIVE;
                        end
                    end
                    ACTIVE: if (strobe) begin
                        pix_q <= pix_q + 1'b1;
                        if (pix_q == LAST_PIX) begin
                            rd_irq   <= 1'b1;
                            ob_level <= ob_avg_q;
                            state_q  <= DONE;
                        end
                    end
                    DONE: if (ack) begin
                        rd_irq     <= 1'b0;
                        overrun    <= 1'b0;
                        short_line <= 1'b0;
                        cnt_q      <= '0;
                        pix_q      <= '0;
                        acc_q      <= '0;
                        state_q    <= sh_rise ? DUMMY : IDLE;
                    end else if (sh_rise) begin
                        overrun <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Line buffer is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[pix_q] <= pix_val;
    end
endmodule

// File: tb/tb_ccd_line_capture.sv
// tb_ccd_line_capture: directed scoreboard bench for ccd_line_capture.
module tb_ccd_line_capture;
    localparam int ADC_W = 12;
    localparam int AW    = 3;

    logic             clk = 1'b0, rst = 1'b1, SH = 1'b0, RS = 1'b1;
    logic             bl_en = 1'b0, cpu_irq = 1'b0;
    logic             rd_req = 1'b0, rd_vld = 1'b0, irq_prev = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic [AW-1:0]    rd_addr = '0;
    logic [ADC_W-1:0] rd_data, ob_level;
    logic             rd_irq, overrun, short_line;

    int checks = 0, errors = 0;
    int ob_v[4], act_v[8], exp_buf[8];
    int exp_irq_q[$], exp_rd_q[$];

    always #5 clk = ~clk;

    ccd_line_capture #(
        .ADC_W(ADC_W), .DUMMY_PIX(4), .OB_LOG2(2), .ACTIVE_PIX(8),
        .AW(AW), .SAMPLE_DLY(2)
    ) dut (
        .clk(clk), .rst(rst), .SH(SH), .RS(RS), .adc_data(adc_data),
        .bl_en(bl_en), .cpu_irq(cpu_irq), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_irq(rd_irq), .ob_level(ob_level),
        .overrun(overrun), .short_line(short_line)
    );

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pixel: RS low 3 clocks, high 1 clock; strobe lands 2 clocks after the fall.
    task automatic pix(input int v, input bit chk_irq);
        RS = 1'b0;
        adc_data = ADC_W'(v);
        step();
        step();
        if (chk_irq) chk("irq_before_last", 32'(rd_irq), 0);
        step();
        if (chk_irq) chk("irq_after_last", 32'(rd_irq), 1);
        RS = 1'b1;
        step();
    endtask

    task automatic run_line(input bit bl, input int n_act, input bit done_exp,
                            input int exp_ob, input bit ack);
        bl_en = bl;
        if (done_exp) exp_irq_q.push_back(exp_ob);
        SH = 1'b1;
        cpu_irq = ack;
        step();
        if (ack) begin
            chk("collide_irq", 32'(rd_irq), 0);
            chk("collide_overrun", 32'(overrun), 0);
        end
        SH = 1'b0;
        step();
        cpu_irq = 1'b0;
        repeat (4) pix(0, 1'b0);
        for (int i = 0; i < 4; i++) pix(ob_v[i], 1'b0);
        for (int i = 0; i < n_act; i++) pix(act_v[i], done_exp && i == n_act - 1);
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) begin
            rd_addr = AW'(i);
            rd_req = 1'b1;
            exp_rd_q.push_back(exp_buf[i]);
            step();
        end
        rd_req = 1'b0;
        step();
        step();
    endtask

    task automatic ack_line();
        chk("irq_before_ack", 32'(rd_irq), 1);
        cpu_irq = 1'b1;
        step();
        chk("irq_after_ack", 32'(rd_irq), 0);
        step();
        step();
        cpu_irq = 1'b0;
        step();
    endtask

    task automatic ramp(input int base, input int stride);
        for (int i = 0; i < 8; i++) act_v[i] = base + i * stride;
    endtask

    task automatic exp_ramp(input int base, input int stride);
        for (int i = 0; i < 8; i++) exp_buf[i] = base + i * stride;
    endtask

    always @(posedge clk) rd_vld <= rd_req;

    // Monitor: compares read data and line-ready events against the queues.
    always @(negedge clk) begin
        int e;
        if (rd_vld) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_data unexpected read got %0d", rd_data);
            end else begin
                e = exp_rd_q.pop_front();
                chk("rd_data", 32'(rd_data), e);
            end
        end
        if (rd_irq && !irq_prev) begin
            if (exp_irq_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_irq unexpected rise got 1 expected 0");
            end else begin
                e = exp_irq_q.pop_front();
                chk("ob_level", 32'(ob_level), e);
            end
        end
        irq_prev <= rd_irq;
    end

    initial begin
        repeat (3) step();
        chk("rst_rd_irq", 32'(rd_irq), 0);
        chk("rst_ob_level", 32'(ob_level), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_short_line", 32'(short_line), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        step();

        ob_v = '{100, 102, 98, 100};
        ramp(200, 1);
        run_line(1'b1, 8, 1'b1, 100, 1'b0);
        exp_ramp(100, 1);
        read_all();
        ack_line();

        ob_v = '{100, 100, 100, 100};
        act_v = '{50, 100, 99, 101, 4095, 0, 150, 112};
        run_line(1'b1, 8, 1'b1, 100, 1'b0);
        exp_buf = '{0, 0, 0, 1, 3995, 0, 50, 12};
        read_all();
        ack_line();

        ob_v = '{7, 8, 9, 10};
        run_line(1'b0, 8, 1'b1, 8, 1'b0);
        exp_buf = act_v;
        read_all();

        ob_v = '{0, 0, 0, 0};
        ramp(1, 1);
        run_line(1'b0, 8, 1'b0, 0, 1'b0);
        chk("overrun_set", 32'(overrun), 1);
        chk("overrun_irq_held", 32'(rd_irq), 1);
        read_all();

        ob_v = '{40, 44, 48, 52};
        ramp(46, 1);
        run_line(1'b1, 8, 1'b1, 46, 1'b1);
        exp_ramp(0, 1);
        read_all();
        chk("collide_no_overrun", 32'(overrun), 0);
        ack_line();

        ob_v = '{0, 0, 0, 0};
        act_v = '{9, 9, 9, 9, 9, 9, 9, 9};
        run_line(1'b1, 3, 1'b0, 0, 1'b0);
        chk("partial_no_irq", 32'(rd_irq), 0);
        ob_v = '{200, 200, 200, 200};
        ramp(300, 10);
        run_line(1'b1, 8, 1'b1, 200, 1'b0);
        chk("abort_short_line", 32'(short_line), 1);
        exp_ramp(100, 10);
        read_all();
        ack_line();
        chk("ack_clears_short", 32'(short_line), 0);

        run_line(1'b1, 3, 1'b0, 0, 1'b0);
        run_line(1'b1, 5, 1'b0, 0, 1'b0);
        chk("abort2_short_line", 32'(short_line), 1);
        chk("abort2_no_irq", 32'(rd_irq), 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_irq", 32'(rd_irq), 0);
        chk("mid_rst_ob_level", 32'(ob_level), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        chk("mid_rst_short_line", 32'(short_line), 0);
        step();
        step();
        rst = 1'b0;
        step();

        ob_v = '{10, 11, 12, 13};
        ramp(20, 1);
        run_line(1'b1, 8, 1'b1, 11, 1'b0);
        exp_ramp(9, 1);
        read_all();
        chk("post_rst_overrun", 32'(overrun), 0);
        chk("post_rst_short_line", 32'(short_line), 0);
        ack_line();

        chk("irq_queue_drained", 32'(exp_irq_q.size()), 0);
        chk("rd_queue_drained", 32'(exp_rd_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ccd_line_capture.md
Name: ccd_line_capture

Overview:
- Receive side of the CCD driver's readout interface. It watches the SH/RS timing that the driver emits and samples the external ADC on every pixel.
- It discards dummy pixels and averages optical-black pixels. Active pixels are black-level-corrected and written into a line buffer.
- When a line is complete it raises rd_irq, holds it until the CPU acknowledges on cpu_irq, and lets the CPU read pixels out by address meanwhile.

Parameters:
- ADC_W, 12, ADC sample width and pixel width.
- DUMMY_PIX, 16, leading pixels discarded after SH.
- OB_LOG2, 3, log2 of the optical-black pixel count (8 OB pixels) that follow the dummies.
- ACTIVE_PIX, 2048, active pixels stored per line.
- AW, 11, buffer address width; ACTIVE_PIX <= 2**AW.
- SAMPLE_DLY, 2, clocks from RS falling edge to ADC sample; must be >= 1.

Ports:
- clk in 1: system clock, same domain as the CCD driver.
- rst in 1: asynchronous active-high reset.
- SH in 1: shift pulse from the driver; its rising edge starts a line.
- RS in 1: reset gate from the driver; one falling edge per pixel.
- adc_data in ADC_W: ADC conversion result.
- bl_en in 1: 1 = subtract black level, 0 = store raw samples.
- cpu_irq in 1: CPU acknowledge; its rising edge releases the line.
- rd_addr in AW: CPU read address.
- rd_data out ADC_W: buffer data, registered.
- rd_irq out 1: line ready interrupt.
- ob_level out ADC_W: black average of the last completed line.
- overrun out 1: sticky flag, a line was dropped.
- short_line out 1: sticky flag, a line was aborted.

Behaviour:
- Reset: rd_irq, overrun, short_line, ob_level and rd_data are 0. State is IDLE and all counters are 0. Buffer contents are not cleared.
- Edge detection: SH and RS are registered once. rise = SH & ~SH_q; fall = ~RS & RS_q. No synchronizer is used because the inputs come from the same clock domain.
- Sample strobe: each RS fall enters a SAMPLE_DLY-deep shift register. adc_data is captured in the cycle the strobe exits. Back-to-back RS edges are all sampled, with no loss.
- States:
  - IDLE: on SH rise go to DUMMY; clear pix_cnt and the accumulator.
  - DUMMY: count strobes; after DUMMY_PIX strobes go to BLACK.
  - BLACK: add each sample into an (ADC_W+OB_LOG2)-bit accumulator. After 2**OB_LOG2 strobes, ob_avg = acc >> OB_LOG2, then go to ACTIVE.
  - ACTIVE: on each strobe write pixel to buffer[pix_cnt] and increment pix_cnt.
    - Pixel value with bl_en=1: adc_data - ob_avg, saturated to 0 when negative.
    - Pixel value with bl_en=0: adc_data.
    - After the ACTIVE_PIX-th write: set rd_irq=1 and ob_level=ob_avg in the same cycle, then go to DONE.
  - DONE: rd_irq held at 1.
    - cpu_irq rise: rd_irq falls next cycle, overrun and short_line clear, go to IDLE.
- SH rise while in DUMMY, BLACK or ACTIVE: abort the line and restart at DUMMY with counters and accumulator cleared. Set short_line=1. rd_irq is not raised.
- SH rise in DONE without an ack: the line is ignored, overrun=1, state stays DONE.
- cpu_irq rise and SH rise in the same DONE cycle: the ack wins, rd_irq clears, go straight to DUMMY, no overrun.
- cpu_irq rise outside DONE: ignored.
- Strobes in IDLE or DONE: ignored, and the buffer is not written.
- Read port:
  - rd_data = buffer[rd_addr] with 1-clock latency.
  - Reading and writing the same address in the same cycle returns the old data.
  - Reads are valid in any state; data is stable only in DONE.
  - rd_addr >= ACTIVE_PIX returns undefined data.
- Asynchronous reset mid-line: immediate return to IDLE with all outputs 0. The next SH rise starts a fresh line.

Test Plan:
All scenarios use DUMMY_PIX=4, OB_LOG2=2, ACTIVE_PIX=8, SAMPLE_DLY=2, and RS with a 4-clock period.
- Basic line: SH pulse, 4 dummies, OB samples 100,102,98,100, active samples 200..207, bl_en=1 -> ob_level=100; buffer[0..7]=100..107; rd_irq rises 1 clk after the 8th sample.
- Saturation and raw mode: OB average 100, active sample 50 -> stores 0. Repeat with bl_en=0 -> stores 50.
- Ack handshake: in DONE, read addr 0..7 -> rd_data matches one clock after each address. Pulse cpu_irq high for 3 clks -> rd_irq=0 on the next clk; a second SH then captures a new line.
- Overrun and collision: SH rise while in DONE -> overrun=1 and the buffer is unchanged. Then cpu_irq rise coinciding with SH rise -> rd_irq=0, overrun=0, and the new line is captured.
- Abort: SH rise after 3 active pixels -> short_line=1, no rd_irq; the following full line completes normally.
- Reset: assert rst mid-ACTIVE -> rd_irq, ob_level, overrun and short_line are 0 immediately; after release, a full line completes correctly.
